// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - shared branch condition codes, flag indices and PC step for KGPminiRISC
package kgp_pkg;

    localparam logic [2:0] COND_NONE = 3'b000;
    localparam logic [2:0] COND_LTZ  = 3'b001;
    localparam logic [2:0] COND_Z    = 3'b010;
    localparam logic [2:0] COND_NZ   = 3'b011;
    localparam logic [2:0] COND_CY   = 3'b100;
    localparam logic [2:0] COND_NCY  = 3'b101;

    // Bit positions inside the {carry, zero, sign} flag register
    localparam int FLG_CY = 2;
    localparam int FLG_Z  = 1;
    localparam int FLG_S  = 0;

    localparam int PC_INC = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational evaluation of the branch condition code
module branch_cond_eval
    import kgp_pkg::*;
(
    input  logic [2:0]  cond_jump,
    input  logic [31:0] rs_val,
    input  logic        carry,
    output logic        cond_true,
    output logic        cond_reserved
);

    always_comb begin
        cond_true     = 1'b0;
        cond_reserved = 1'b0;
        case (cond_jump)
            COND_NONE: cond_true = 1'b0;
            COND_LTZ:  cond_true = rs_val[31];
            COND_Z:    cond_true = (rs_val == 32'd0);
            COND_NZ:   cond_true = (rs_val != 32'd0);
            COND_CY:   cond_true = carry;
            COND_NCY:  cond_true = ~carry;
            default:   cond_reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - PC register, flag register, branch resolution and link generation
module branch_pc_unit
    import kgp_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [2:0]          cond_jump,
    input  logic                uncond_jump,
    input  logic                is_link,
    input  logic                br_reg,
    input  logic [31:0]         rs_val,
    input  logic [PC_WIDTH-1:0] imm_offset,
    input  logic                flag_we,
    input  logic                alu_carry,
    input  logic                alu_zero,
    input  logic                alu_sign,
    output logic [PC_WIDTH-1:0] pc,
    output logic                taken,
    output logic                link_we,
    output logic [PC_WIDTH-1:0] link_data,
    output logic                redirect,
    output logic                cond_err,
    output logic [2:0]          flags
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] rs_trunc;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_next;
    logic [2:0]          flags_q;
    logic                redirect_q;
    logic                cond_err_q;
    logic                cond_true;
    logic                cond_reserved;

    branch_cond_eval u_cond (
        .cond_jump     (cond_jump),
        .rs_val        (rs_val),
        .carry         (flags_q[FLG_CY]),
        .cond_true     (cond_true),
        .cond_reserved (cond_reserved)
    );

    // Register targets are word-aligned by dropping the low two bits
    always_comb begin
        pc_plus4 = pc_q + PC_WIDTH'(PC_INC);
        rs_trunc = PC_WIDTH'(rs_val);
        target   = br_reg ? {rs_trunc[PC_WIDTH-1:2], 2'b00}
                          : pc_plus4 + imm_offset;
        taken    = uncond_jump | cond_true;
        pc_next  = taken ? target : pc_plus4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            flags_q    <= 3'b000;
            redirect_q <= 1'b0;
            cond_err_q <= 1'b0;
        end else if (en) begin
            pc_q       <= pc_next;
            redirect_q <= taken;
            if (cond_reserved && !uncond_jump) begin
                cond_err_q <= 1'b1;
            end
            // Flag capture happens after the branch test, so bcy/bncy see the old carry
            if (flag_we) begin
                flags_q[FLG_CY] <= alu_carry;
                flags_q[FLG_Z]  <= alu_zero;
                flags_q[FLG_S]  <= alu_sign;
            end
        end
    end

    assign pc        = pc_q;
    assign link_we   = is_link & uncond_jump & en;
    assign link_data = pc_plus4;
    assign redirect  = redirect_q;
    assign cond_err  = cond_err_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - randomized and directed self-checking bench for branch_pc_unit
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  cond_jump = 3'd0;
    logic        uncond_jump = 1'b0;
    logic        is_link = 1'b0;
    logic        br_reg = 1'b0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] imm_offset = 32'd0;
    logic        flag_we = 1'b0;
    logic        alu_carry = 1'b0;
    logic        alu_zero = 1'b0;
    logic        alu_sign = 1'b0;
    logic [31:0] pc;
    logic        taken;
    logic        link_we;
    logic [31:0] link_data;
    logic        redirect;
    logic        cond_err;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    logic [31:0] m_pc = 32'd0;
    logic [2:0]  m_flags = 3'd0;
    logic        m_redir = 1'b0;
    logic        m_err = 1'b0;

    branch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cond_jump(cond_jump),
        .uncond_jump(uncond_jump), .is_link(is_link), .br_reg(br_reg),
        .rs_val(rs_val), .imm_offset(imm_offset), .flag_we(flag_we),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .pc(pc), .taken(taken), .link_we(link_we), .link_data(link_data),
        .redirect(redirect), .cond_err(cond_err), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of each condition code; flags are {carry, zero, sign}
    function automatic bit cond_holds(input logic [2:0] c, input logic [31:0] rs, input bit cy);
        case (c)
            3'd1:    return $signed(rs) < 0;
            3'd2:    return rs == 0;
            3'd3:    return rs != 0;
            3'd4:    return cy;
            3'd5:    return !cy;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_taken();
        return uncond_jump || cond_holds(cond_jump, rs_val, m_flags[2]);
    endfunction

    function automatic logic [31:0] m_next();
        if (!m_taken()) return m_pc + 32'd4;
        if (br_reg) return rs_val & 32'hFFFF_FFFC;
        return m_pc + 32'd4 + imm_offset;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 32'd0;
            m_flags <= 3'd0;
            m_redir <= 1'b0;
            m_err   <= 1'b0;
        end else if (en) begin
            m_pc    <= m_next();
            m_redir <= m_taken();
            if (!uncond_jump && cond_jump >= 3'd6) m_err <= 1'b1;
            if (flag_we) m_flags <= {alu_carry, alu_zero, alu_sign};
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("pc", pc, m_pc);
            check("flags", 32'(flags), 32'(m_flags));
            check("redirect", 32'(redirect), 32'(m_redir));
            check("cond_err", 32'(cond_err), 32'(m_err));
            check("taken", 32'(taken), 32'(m_taken()));
            check("link_we", 32'(link_we), 32'(is_link & uncond_jump & en));
            check("link_data", link_data, m_pc + 32'd4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en = 1'b1; cond_jump = 3'd0; uncond_jump = 1'b0; is_link = 1'b0;
        br_reg = 1'b0; rs_val = 32'd0; imm_offset = 32'd0; flag_we = 1'b0;
        alu_carry = 1'b0; alu_zero = 1'b0; alu_sign = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] addr);
        clear_inputs();
        uncond_jump = 1'b1; br_reg = 1'b1; rs_val = addr;
        tick();
        clear_inputs();
        check("jump_to_pc", pc, addr);
    endtask

    initial begin
        tick();
        tick();
        cmp_on = 1'b1;
        check("rst_pc", pc, 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_redirect", 32'(redirect), 32'h0);
        check("rst_cond_err", 32'(cond_err), 32'h0);
        check("rst_link_data", link_data, 32'h4);

        rst_n = 1'b1;
        clear_inputs();
        tick(); check("seq_pc1", pc, 32'h4);
        tick(); check("seq_pc2", pc, 32'h8);
        tick(); check("seq_pc3", pc, 32'hC); check("seq_redirect", 32'(redirect), 32'h0);

        jump_to(32'h10);
        cond_jump = 3'd2; rs_val = 32'd0; imm_offset = 32'h20;
        #1 check("bz_taken", 32'(taken), 32'h1);
        tick(); check("bz_pc", pc, 32'h34); check("bz_redirect", 32'(redirect), 32'h1);
        clear_inputs();
        tick(); check("bz_redirect_drop", 32'(redirect), 32'h0);
        jump_to(32'h10);
        cond_jump = 3'd2; rs_val = 32'd5; imm_offset = 32'h20;
        #1 check("bz_not_taken", 32'(taken), 32'h0);
        tick(); check("bz_nt_pc", pc, 32'h14);

        jump_to(32'h8);
        flag_we = 1'b1; alu_carry = 1'b1;
        tick(); check("flag_cap", 32'(flags), 32'h4); check("flag_pc", pc, 32'hC);
        clear_inputs();
        cond_jump = 3'd4; imm_offset = 32'hFFFF_FFF8;
        #1 check("bcy_taken", 32'(taken), 32'h1);
        tick(); check("bcy_pc", pc, 32'h8);
        clear_inputs();
        flag_we = 1'b1;
        tick(); check("flag_clear", 32'(flags), 32'h0);
        flag_we = 1'b1; alu_carry = 1'b1; cond_jump = 3'd4; imm_offset = 32'hFFFF_FFF8;
        #1 check("bcy_old_carry", 32'(taken), 32'h0);
        tick(); check("bcy_old_pc", pc, 32'h10); check("bcy_old_flags", 32'(flags), 32'h4);

        jump_to(32'h40);
        uncond_jump = 1'b1; is_link = 1'b1; br_reg = 1'b1; rs_val = 32'h103;
        #1 check("bl_link_we", 32'(link_we), 32'h1); check("bl_link_data", link_data, 32'h44);
        tick(); check("br_pc", pc, 32'h100);

        clear_inputs();
        cond_jump = 3'd7; uncond_jump = 1'b1;
        #1 check("rsv_uncond_taken", 32'(taken), 32'h1);
        tick(); check("rsv_uncond_err", 32'(cond_err), 32'h0); check("rsv_uncond_pc", pc, 32'h104);
        uncond_jump = 1'b0;
        #1 check("rsv_taken", 32'(taken), 32'h0);
        tick(); check("rsv_err", 32'(cond_err), 32'h1);
        clear_inputs();
        tick(); check("rsv_err_sticky", 32'(cond_err), 32'h1);

        jump_to(32'hFFFF_FFFC);
        tick(); check("wrap_pc", pc, 32'h0);
        tick(); check("post_wrap_pc", pc, 32'h4);

        uncond_jump = 1'b1; br_reg = 1'b1; rs_val = 32'h200; is_link = 1'b1; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_pc", pc, 32'h4);
            check("stall_link_we", 32'(link_we), 32'h0);
            check("stall_taken", 32'(taken), 32'h1);
        end
        #2 rst_n = 1'b0;
        #1 check("midstall_rst_pc", pc, 32'h0); check("midstall_rst_err", 32'(cond_err), 32'h0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        check("post_rst_pc", pc, 32'h0);
        tick(); check("post_rst_pc2", pc, 32'h4);

        for (int n = 0; n < 600; n++) begin
            en          = ($urandom_range(0, 4) != 0);
            cond_jump   = 3'($urandom_range(0, 7));
            if (cond_jump >= 3'd6 && $urandom_range(0, 3) != 0) cond_jump = 3'd0;
            uncond_jump = ($urandom_range(0, 5) == 0);
            is_link     = 1'($urandom_range(0, 1));
            br_reg      = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rs_val = 32'd0;
                1:       rs_val = 32'h8000_0000 | $urandom;
                2:       rs_val = 32'($urandom_range(1, 64));
                default: rs_val = $urandom;
            endcase
            imm_offset  = 32'($urandom_range(0, 255)) * 32'd4 - 32'd512;
            flag_we     = 1'($urandom_range(0, 1));
            alu_carry   = 1'($urandom_range(0, 1));
            alu_zero    = 1'($urandom_range(0, 1));
            alu_sign    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
